// File: rtl/ptw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ptw_pkg
// Purpose  : Types and constants shared by the page-table walker and the TLB.
// Revision : 1.0 - initial release
// ============================================================================
package ptw_pkg;

    typedef struct packed {
        logic [19:0] ppn;
        logic [7:0]  rsvd;
        logic        v;
        logic        w;
        logic        r;
        logic        x;
    } pte_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_L1_REQ  = 3'd1,
        S_L1_WAIT = 3'd2,
        S_L0_REQ  = 3'd3,
        S_L0_WAIT = 3'd4,
        S_RESP    = 3'd5
    } ptw_state_e;

    localparam logic [1:0] FC_INVALID  = 2'd0;
    localparam logic [1:0] FC_RSVD     = 2'd1;
    localparam logic [1:0] FC_MISALIGN = 2'd2;
    localparam logic [1:0] FC_BUS      = 2'd3;

    // Word-aligned address of entry idx inside the table at table_ppn.
    function automatic logic [31:0] pte_addr(input logic [19:0] table_ppn,
                                             input logic [9:0]  idx);
        return {table_ppn, idx, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ptw_pte_check.sv
`default_nettype none
// ============================================================================
// Module   : ptw_pte_check
// Purpose  : Combinational PTE classifier: pointer / leaf / fault with cause.
// Revision : 1.0 - initial release
// ============================================================================
module ptw_pte_check
    import ptw_pkg::*;
(
    input  pte_t       pte,
    input  logic       level,
    output logic       is_leaf,
    output logic       is_ptr,
    output logic       fault,
    output logic [1:0] cause
);

    logic w_unused_rsvd;
    assign w_unused_rsvd = ^pte.rsvd;

    // level=1 is the root table, where superpage leaves must be 4 MiB aligned.
    always_comb begin
        is_leaf = 1'b0;
        is_ptr  = 1'b0;
        fault   = 1'b0;
        cause   = FC_INVALID;
        if (!pte.v) begin
            fault = 1'b1;
            cause = FC_INVALID;
        end else if ({pte.w, pte.r, pte.x} == 3'b000) begin
            if (level) begin
                is_ptr = 1'b1;
            end else begin
                fault = 1'b1;
                cause = FC_RSVD;
            end
        end else if (pte.w && !pte.r) begin
            fault = 1'b1;
            cause = FC_RSVD;
        end else begin
            is_leaf = 1'b1;
            if (level && (pte.ppn[9:0] != 10'd0)) begin
                fault = 1'b1;
                cause = FC_MISALIGN;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/page_table_walker.sv
`default_nettype none
// ============================================================================
// Module   : page_table_walker
// Purpose  : Two-level (10/10/12) page-table walker with a single-outstanding
//            memory read port; returns a 4 KiB-normalised leaf PTE or a fault.
// Revision : 1.0 - initial release
// ============================================================================
module page_table_walker
    import ptw_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TMO_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] root_ppn_i,
    input  logic        ptw_req_i,
    input  logic [31:0] ptw_vaddr_i,
    output logic        ptw_resp_valid_o,
    output logic [31:0] ptw_pte_o,
    output logic        ptw_fault_o,
    output logic [1:0]  ptw_fault_cause_o,
    output logic        busy_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    ptw_state_e        r_state;
    ptw_state_e        w_state_next;
    logic [19:0]       r_vpn;
    logic [19:0]       r_root_ppn;
    logic [19:0]       r_l0_ppn;
    logic [31:0]       r_pte;
    logic              r_fault;
    logic [1:0]        r_cause;
    logic [TMO_W-1:0]  r_tmo;

    logic              w_done;
    logic              w_done_fault;
    logic [1:0]        w_done_cause;
    logic [31:0]       w_done_pte;
    logic              w_load_l0;
    logic              w_in_mem;
    logic              w_tmo_expire;

    pte_t              w_rd_pte;
    logic              w_chk_level;
    logic              w_chk_leaf;
    logic              w_chk_ptr;
    logic              w_chk_fault;
    logic [1:0]        w_chk_cause;

    logic              w_unused_vaddr;
    assign w_unused_vaddr = ^ptw_vaddr_i[11:0];

    assign w_rd_pte    = mem_rdata_i;
    assign w_chk_level = (r_state == S_L1_WAIT);

    ptw_pte_check u_pte_check (
        .pte     (w_rd_pte),
        .level   (w_chk_level),
        .is_leaf (w_chk_leaf),
        .is_ptr  (w_chk_ptr),
        .fault   (w_chk_fault),
        .cause   (w_chk_cause)
    );

    assign w_in_mem = (r_state == S_L1_REQ) || (r_state == S_L1_WAIT) ||
                      (r_state == S_L0_REQ) || (r_state == S_L0_WAIT);
    assign w_tmo_expire = (TIMEOUT_CYCLES != 0) && w_in_mem && (r_tmo == C_TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        w_done       = 1'b0;
        w_done_fault = 1'b0;
        w_done_cause = FC_INVALID;
        w_done_pte   = '0;
        w_load_l0    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ptw_req_i) begin
                    w_state_next = S_L1_REQ;
                end
            end
            // On expiry the request is withdrawn in the same cycle, so a late
            // grant cannot create an access the walker no longer tracks.
            S_L1_REQ, S_L0_REQ: begin
                if (w_tmo_expire) begin
                    w_done       = 1'b1;
                    w_done_fault = 1'b1;
                    w_done_cause = FC_BUS;
                end else begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = (r_state == S_L1_REQ) ? pte_addr(r_root_ppn, r_vpn[19:10])
                                                       : pte_addr(r_l0_ppn, r_vpn[9:0]);
                    if (mem_gnt_i) begin
                        w_state_next = (r_state == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
                    end
                end
            end
            S_L1_WAIT, S_L0_WAIT: begin
                if (mem_rvalid_i) begin
                    if (mem_err_i) begin
                        w_done       = 1'b1;
                        w_done_fault = 1'b1;
                        w_done_cause = FC_BUS;
                    end else if (w_chk_fault) begin
                        w_done       = 1'b1;
                        w_done_fault = 1'b1;
                        w_done_cause = w_chk_cause;
                    end else if (w_chk_ptr) begin
                        w_load_l0    = 1'b1;
                        w_state_next = S_L0_REQ;
                    end else if (w_chk_leaf) begin
                        w_done     = 1'b1;
                        w_done_pte = w_chk_level
                                   ? {mem_rdata_i[31:22], r_vpn[9:0], 8'h00, mem_rdata_i[3:0]}
                                   : {mem_rdata_i[31:12], 8'h00, mem_rdata_i[3:0]};
                    end
                end else if (w_tmo_expire) begin
                    w_done       = 1'b1;
                    w_done_fault = 1'b1;
                    w_done_cause = FC_BUS;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (w_done) begin
            w_state_next = S_RESP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vpn      <= '0;
            r_root_ppn <= '0;
            r_l0_ppn   <= '0;
            r_pte      <= '0;
            r_fault    <= 1'b0;
            r_cause    <= FC_INVALID;
            r_tmo      <= '0;
        end else begin
            if ((r_state == S_IDLE) && ptw_req_i) begin
                r_vpn      <= ptw_vaddr_i[31:12];
                r_root_ppn <= root_ppn_i;
            end
            if (w_load_l0) begin
                r_l0_ppn <= mem_rdata_i[31:12];
            end
            // Result registers are only non-zero while the response is presented.
            if (w_done) begin
                r_pte   <= w_done_fault ? 32'h0 : w_done_pte;
                r_fault <= w_done_fault;
                r_cause <= w_done_cause;
            end else if (r_state == S_RESP) begin
                r_pte   <= '0;
                r_fault <= 1'b0;
                r_cause <= FC_INVALID;
            end
            if ((w_state_next != r_state) || !w_in_mem) begin
                r_tmo <= '0;
            end else if (TIMEOUT_CYCLES != 0) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
        end
    end

    assign ptw_resp_valid_o  = (r_state == S_RESP);
    assign ptw_pte_o         = r_pte;
    assign ptw_fault_o       = r_fault;
    assign ptw_fault_cause_o = r_cause;
    assign busy_o            = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_page_table_walker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_page_table_walker
// Purpose  : Self-checking bench: directed walks plus randomised page tables.
// Revision : 1.0 - initial release
// ============================================================================
module tb_page_table_walker;

    localparam int TMO = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] root_ppn = '0;
    logic        ptw_req = 1'b0;
    logic [31:0] ptw_vaddr = '0;
    logic        ptw_resp_valid;
    logic [31:0] ptw_pte;
    logic        ptw_fault;
    logic [1:0]  ptw_fault_cause;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_err = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [logic [31:0]];

    typedef struct {
        logic [31:0] pte;
        logic        flt;
        logic [1:0]  cause;
        int          lat;
        int          nacc;
        int          addr_bad;
        int          req_cyc;
        logic        busy_after;
        logic        resp_again;
    } res_t;

    page_table_walker #(.TIMEOUT_CYCLES(TMO), .TMO_W(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .root_ppn_i        (root_ppn),
        .ptw_req_i         (ptw_req),
        .ptw_vaddr_i       (ptw_vaddr),
        .ptw_resp_valid_o  (ptw_resp_valid),
        .ptw_pte_o         (ptw_pte),
        .ptw_fault_o       (ptw_fault),
        .ptw_fault_cause_o (ptw_fault_cause),
        .busy_o            (busy),
        .mem_req_o         (mem_req),
        .mem_addr_o        (mem_addr),
        .mem_gnt_i         (mem_gnt),
        .mem_rvalid_i      (mem_rvalid),
        .mem_rdata_i       (mem_rdata),
        .mem_err_i         (mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Reference walk: applies the translation rules directly to the memory image.
    function automatic void model(input logic [19:0] root, input logic [31:0] va,
                                  input int gdly, input int rdly, input int err_acc,
                                  output res_t e);
        logic [31:0] p;
        e.pte = 32'h0; e.flt = 1'b0; e.cause = 2'd0; e.addr_bad = 0; e.req_cyc = 0;
        e.busy_after = 1'b0; e.resp_again = 1'b0;
        e.nacc = 1;
        p = rd({root, va[31:22], 2'b00});
        if (err_acc == 1) begin e.flt = 1'b1; e.cause = 2'd3; end
        else if (!p[3]) begin e.flt = 1'b1; e.cause = 2'd0; end
        else if (p[2:1] == 2'b10) begin e.flt = 1'b1; e.cause = 2'd1; end
        else if (p[2:0] == 3'b000) begin
            e.nacc = 2;
            p = rd({p[31:12], va[21:12], 2'b00});
            if (err_acc == 2) begin e.flt = 1'b1; e.cause = 2'd3; end
            else if (!p[3]) begin e.flt = 1'b1; e.cause = 2'd0; end
            else if (p[2:0] == 3'b000 || p[2:1] == 2'b10) begin e.flt = 1'b1; e.cause = 2'd1; end
            else e.pte = {p[31:12], 8'h00, p[3:0]};
        end
        else if (p[21:12] != 10'd0) begin e.flt = 1'b1; e.cause = 2'd2; end
        else e.pte = {p[31:22], va[21:12], 8'h00, p[3:0]};
        e.lat = 1 + e.nacc * (gdly + 1 + rdly);
    endfunction

    function automatic logic [31:0] rand_pte(input int lvl);
        logic [31:0] p;
        p = $urandom;
        if (lvl == 1 && $urandom_range(0, 1) == 1) begin
            p[3] = 1'b1; p[2:0] = 3'b000;
        end else begin
            case ($urandom_range(0, 5))
                0: p[3] = 1'b0;
                1: begin p[3] = 1'b1; p[2:0] = 3'b000; end
                2: begin p[3] = 1'b1; p[2:1] = 2'b10; end
                3: begin p[3] = 1'b1; p[1] = 1'b1; p[21:12] = 10'd0; end
                default: begin p[3] = 1'b1; p[1] = 1'b1; end
            endcase
        end
        return p;
    endfunction

    // Issues one walk and acts as the memory slave with the given delays.
    task automatic run_walk(input logic [19:0] root, input logic [31:0] va,
                            input int gdly, input int rdly, input int err_acc,
                            input bit poke, output res_t r);
        int          held;
        int          rv_cnt;
        bit          pend;
        bit          done;
        logic [31:0] addr_q;
        held = 0; rv_cnt = 0; pend = 0; done = 0; addr_q = '0;
        r.pte = '0; r.flt = 1'b0; r.cause = '0; r.lat = 0; r.nacc = 0;
        r.addr_bad = 0; r.req_cyc = 0; r.busy_after = 1'b0; r.resp_again = 1'b0;
        @(negedge clk);
        root_ppn = root; ptw_vaddr = va; ptw_req = 1'b1;
        for (int c = 1; c <= 2000 && !done; c++) begin
            @(negedge clk);
            ptw_req    = (poke && c == 2);
            root_ppn   = 20'($urandom);
            ptw_vaddr  = $urandom;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_err    = 1'b0;
            mem_rdata  = $urandom;
            if (ptw_resp_valid) begin
                r.pte = ptw_pte; r.flt = ptw_fault; r.cause = ptw_fault_cause;
                r.lat = c; done = 1;
            end else if (pend) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd(addr_q);
                    mem_err    = (r.nacc == err_acc);
                    pend       = 0;
                end
            end else if (mem_req) begin
                r.req_cyc++;
                if (held == 0) addr_q = mem_addr;
                else if (mem_addr !== addr_q) r.addr_bad++;
                if (held == gdly) begin
                    mem_gnt = 1'b1; pend = 1; rv_cnt = rdly; r.nacc++; held = 0;
                end else begin
                    held++;
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL walk_timeout: no response, got 0 required 1 (va=%h)", va);
        end
        @(negedge clk);
        ptw_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
        r.busy_after = busy;
        r.resp_again = ptw_resp_valid;
    endtask

    task automatic set_two_level(input logic [31:0] l0);
        mem.delete();
        mem[32'h00100004] = 32'h00200008;
        mem[32'h0020000C] = l0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ptw_resp_valid, busy, mem_req, ptw_fault} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000", {ptw_resp_valid, busy, mem_req, ptw_fault});
        end
        checks++;
        if ({ptw_pte, mem_addr, ptw_fault_cause} !== 66'h0) begin
            errors++;
            $display("FAIL reset_data: got pte=%h addr=%h cause=%0d required 0", ptw_pte, mem_addr, ptw_fault_cause);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_two_level();
        res_t r;
        set_two_level(32'h1234500F);
        run_walk(20'h00100, 32'h00403ABC, 0, 1, 0, 0, r);
        checks++;
        if (r.pte !== 32'h1234500F || r.flt !== 1'b0) begin
            errors++;
            $display("FAIL two_level_pte: got %h/%b required 1234500f/0", r.pte, r.flt);
        end
        checks++;
        if (r.lat != 5 || r.nacc != 2) begin
            errors++;
            $display("FAIL two_level_latency: got lat=%0d acc=%0d required 5/2", r.lat, r.nacc);
        end
        checks++;
        if (r.busy_after !== 1'b0 || r.resp_again !== 1'b0) begin
            errors++;
            $display("FAIL two_level_idle: got busy=%b resp=%b required 0/0", r.busy_after, r.resp_again);
        end
    endtask

    task automatic test_superpage();
        res_t r;
        mem.delete();
        mem[32'h0010000C] = 32'h8000000B;
        run_walk(20'h00100, 32'h00C05123, 0, 1, 0, 0, r);
        checks++;
        if (r.pte !== 32'h8000500B || r.flt !== 1'b0 || r.lat != 3 || r.nacc != 1) begin
            errors++;
            $display("FAIL superpage: got pte=%h flt=%b lat=%0d acc=%0d required 8000500b/0/3/1",
                     r.pte, r.flt, r.lat, r.nacc);
        end
        mem[32'h0010000C] = 32'h8000100B;
        run_walk(20'h00100, 32'h00C05123, 0, 1, 0, 0, r);
        checks++;
        if (r.flt !== 1'b1 || r.cause !== 2'd2 || r.pte !== 32'h0) begin
            errors++;
            $display("FAIL superpage_misalign: got flt=%b cause=%0d pte=%h required 1/2/0", r.flt, r.cause, r.pte);
        end
    endtask

    task automatic test_invalid();
        res_t r;
        set_two_level(32'h1234500C);
        run_walk(20'h00100, 32'h00403ABC, 0, 1, 0, 0, r);
        checks++;
        if (r.flt !== 1'b1 || r.cause !== 2'd1 || r.pte !== 32'h0) begin
            errors++;
            $display("FAIL reserved_perm: got flt=%b cause=%0d pte=%h required 1/1/0", r.flt, r.cause, r.pte);
        end
        mem[32'h00100004] = 32'h00000007;
        run_walk(20'h00100, 32'h00403ABC, 0, 1, 0, 0, r);
        checks++;
        if (r.flt !== 1'b1 || r.cause !== 2'd0 || r.nacc != 1) begin
            errors++;
            $display("FAIL invalid_l1: got flt=%b cause=%0d acc=%0d required 1/0/1", r.flt, r.cause, r.nacc);
        end
    endtask

    task automatic test_bus();
        res_t r;
        set_two_level(32'h1234500F);
        run_walk(20'h00100, 32'h00403ABC, 100000, 1, 0, 0, r);
        checks++;
        if (r.flt !== 1'b1 || r.cause !== 2'd3 || r.nacc != 0) begin
            errors++;
            $display("FAIL timeout_fault: got flt=%b cause=%0d acc=%0d required 1/3/0", r.flt, r.cause, r.nacc);
        end
        checks++;
        if (r.req_cyc < TMO - 1 || r.req_cyc > TMO) begin
            errors++;
            $display("FAIL timeout_req_cycles: got %0d required %0d..%0d", r.req_cyc, TMO - 1, TMO);
        end
        run_walk(20'h00100, 32'h00403ABC, 0, 1, 2, 0, r);
        checks++;
        if (r.flt !== 1'b1 || r.cause !== 2'd3 || r.pte !== 32'h0 || r.nacc != 2) begin
            errors++;
            $display("FAIL bus_err_l0: got flt=%b cause=%0d pte=%h acc=%0d required 1/3/0/2",
                     r.flt, r.cause, r.pte, r.nacc);
        end
    endtask

    task automatic test_backpressure();
        res_t r;
        int   extra;
        set_two_level(32'h1234500F);
        run_walk(20'h00100, 32'h00403ABC, 3, 4, 0, 1, r);
        checks++;
        if (r.pte !== 32'h1234500F || r.flt !== 1'b0 || r.addr_bad != 0) begin
            errors++;
            $display("FAIL backpressure_pte: got pte=%h flt=%b unstable=%0d required 1234500f/0/0",
                     r.pte, r.flt, r.addr_bad);
        end
        checks++;
        if (r.lat != 17) begin
            errors++;
            $display("FAIL backpressure_latency: got %0d required 17", r.lat);
        end
        extra = (r.resp_again === 1'b1) ? 1 : 0;
        repeat (8) begin
            @(negedge clk);
            if (ptw_resp_valid === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL busy_req_ignored: got %0d extra active cycles required 0", extra);
        end
    endtask

    task automatic test_reset_midwalk();
        res_t r;
        int   activity;
        set_two_level(32'h1234500F);
        @(negedge clk);
        root_ppn = 20'h00100; ptw_vaddr = 32'h00403ABC; ptw_req = 1'b1;
        @(negedge clk);
        ptw_req = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00200008;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0020000C) begin
            errors++;
            $display("FAIL midwalk_l0_addr: got req=%b addr=%h required 1/0020000c", mem_req, mem_addr);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({busy, mem_req, ptw_resp_valid, ptw_fault} !== 4'b0 || mem_addr !== 32'h0 || ptw_pte !== 32'h0) begin
            errors++;
            $display("FAIL midwalk_reset: got busy=%b req=%b resp=%b addr=%h required all 0",
                     busy, mem_req, ptw_resp_valid, mem_addr);
        end
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h1234500F;
        activity = 0;
        repeat (6) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (ptw_resp_valid === 1'b1 || busy === 1'b1 || mem_req === 1'b1) activity++;
        end
        checks++;
        if (activity != 0) begin
            errors++;
            $display("FAIL stray_rvalid: got %0d active cycles required 0", activity);
        end
        run_walk(20'h00100, 32'h00403ABC, 0, 1, 0, 0, r);
        checks++;
        if (r.pte !== 32'h1234500F || r.flt !== 1'b0 || r.lat != 5) begin
            errors++;
            $display("FAIL after_reset_walk: got pte=%h flt=%b lat=%0d required 1234500f/0/5", r.pte, r.flt, r.lat);
        end
    endtask

    task automatic test_random();
        res_t        r;
        res_t        e;
        logic [19:0] root;
        logic [31:0] va;
        logic [31:0] l1;
        int          gdly;
        int          rdly;
        int          err_acc;
        for (int i = 0; i < 30; i++) begin
            mem.delete();
            root = 20'($urandom);
            va   = $urandom;
            l1   = rand_pte(1);
            mem[{root, va[31:22], 2'b00}] = l1;
            if (l1[3] && l1[2:0] == 3'b000) mem[{l1[31:12], va[21:12], 2'b00}] = rand_pte(0);
            gdly    = $urandom_range(0, 3);
            rdly    = $urandom_range(1, 3);
            err_acc = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
            model(root, va, gdly, rdly, err_acc, e);
            run_walk(root, va, gdly, rdly, err_acc, 0, r);
            checks++;
            if (r.pte !== e.pte || r.flt !== e.flt || r.cause !== e.cause) begin
                errors++;
                $display("FAIL rand_result[%0d]: got pte=%h flt=%b cause=%0d required %h/%b/%0d",
                         i, r.pte, r.flt, r.cause, e.pte, e.flt, e.cause);
            end
            checks++;
            if (r.lat != e.lat || r.nacc != e.nacc || r.addr_bad != 0 || r.busy_after !== 1'b0) begin
                errors++;
                $display("FAIL rand_timing[%0d]: got lat=%0d acc=%0d unstable=%0d busy=%b required %0d/%0d/0/0",
                         i, r.lat, r.nacc, r.addr_bad, r.busy_after, e.lat, e.nacc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_level();
        test_superpage();
        test_invalid();
        test_bus();
        test_backpressure();
        test_reset_midwalk();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
